host_bus_drv: RTL

- Bus initiator for the S1D13700-style 8080 write bus (ce_x, a0, wr_x, dat). It is the transmit end of the same protocol that the LCD-side host interface receives.
- Used by the on-chip init sequencer and test harness to issue one command byte (a0=1) followed by 0..15 parameter bytes (a0=0).
- Each byte is sent as a fully timed bus cycle with programmable setup, strobe, hold and recovery lengths.

---
 rtl/host_bus_pkg.sv | 30 +++
 rtl/host_bus_tmr.sv | 24 ++
 rtl/host_bus_drv.sv | 135 +++++++++++++
 3 files changed

// File: rtl/host_bus_pkg.sv
// Shared encodings and default timing for the 8080-style host bus initiator.
// PTMO_CYC_DEF exists only when HOST_DRV_PTMO_EN is defined.
package host_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RECOV  = 3'd4,
    PWAIT  = 3'd5
  } state_t;

  localparam logic A0_CMD = 1'b1;
  localparam logic A0_DAT = 1'b0;

  localparam int T_SU_DEF = 1;
  localparam int T_WR_DEF = 4;
  localparam int T_HD_DEF = 1;
  localparam int T_RC_DEF = 2;
`ifdef HOST_DRV_PTMO_EN
  localparam int PTMO_CYC_DEF = 255;
`endif

  // Phase counter counts down to 0, so a phase of t clocks loads t-1.
  function automatic logic [3:0] phase_len(input int t);
    return 4'(t - 1);
  endfunction

endpackage

// File: rtl/host_bus_tmr.sv
// Phase down-counter: loads a value on state entry, holds at zero, flags zero.
module host_bus_tmr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/host_bus_drv.sv
// 8080-style write-bus initiator: one command byte then 0..15 parameter bytes.
// Define HOST_DRV_PTMO_EN to abort with an err pulse when a parameter never arrives.
module host_bus_drv
  import host_bus_pkg::*;
#(
  parameter int T_SU = T_SU_DEF,
  parameter int T_WR = T_WR_DEF,
  parameter int T_HD = T_HD_DEF,
  parameter int T_RC = T_RC_DEF
`ifdef HOST_DRV_PTMO_EN
  , parameter int PTMO_CYC = PTMO_CYC_DEF
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_code,
  input  logic [3:0] cmd_plen,
  input  logic       par_valid,
  output logic       par_ready,
  input  logic [7:0] par_data,
  output logic       ce_x,
  output logic       a0,
  output logic       wr_x,
  output logic [7:0] dat,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Handshakes: a byte is taken on a clock edge where valid and ready are both
  // high; ready is registered, so it never depends on valid combinationally.

  state_t     state, state_nx;
  logic [3:0] rem;
  logic       cmd_acc, par_acc, tmo;
  logic       tmr_load, tmr_zero;
  logic [3:0] tmr_val;

  assign cmd_acc = cmd_ready & cmd_valid;
  assign par_acc = par_ready & par_valid;

  host_bus_tmr u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

`ifdef HOST_DRV_PTMO_EN
  logic [7:0] wcnt;

  always_ff @(posedge clk) begin
    if (rst || state != PWAIT) begin
      wcnt <= 8'd0;
    end else begin
      wcnt <= wcnt + 8'd1;
    end
  end

  assign tmo = (state == PWAIT) && !par_acc && (wcnt == 8'(PTMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= tmo;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    tmr_val  = 4'd0;
    case (state)
      IDLE:    if (cmd_acc) state_nx = SETUP;
      SETUP:   if (tmr_zero) state_nx = STROBE;
      STROBE:  if (tmr_zero) state_nx = HOLD;
      HOLD:    if (tmr_zero) state_nx = RECOV;
      RECOV:   if (tmr_zero) state_nx = (rem == 4'd0) ? IDLE : PWAIT;
      PWAIT: begin
        if (par_acc) state_nx = SETUP;
        else if (tmo) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    case (state_nx)
      SETUP:   tmr_val = phase_len(T_SU);
      STROBE:  tmr_val = phase_len(T_WR);
      HOLD:    tmr_val = phase_len(T_HD);
      RECOV:   tmr_val = phase_len(T_RC);
      default: tmr_val = 4'd0;
    endcase
    tmr_load = (state_nx != state);
  end

  // Bus outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= 4'd0;
      ce_x      <= 1'b1;
      wr_x      <= 1'b1;
      a0        <= A0_CMD;
      dat       <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b0;
      par_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      ce_x      <= !(state_nx inside {SETUP, STROBE, HOLD});
      wr_x      <= (state_nx != STROBE);
      busy      <= (state_nx != IDLE);
      cmd_ready <= (state_nx == IDLE);
      par_ready <= (state_nx == PWAIT);
      done      <= (state == RECOV) && tmr_zero && (rem == 4'd0);
      if (cmd_acc) begin
        dat <= cmd_code;
        a0  <= A0_CMD;
        rem <= cmd_plen;
      end else if (par_acc) begin
        dat <= par_data;
        a0  <= A0_DAT;
        rem <= rem - 4'd1;
      end
    end
  end

endmodule
